mod7_sequence_checker: RTL and testbench
========================================

Name: mod7_sequence_checker

Overview:
- Receive-side companion to the team's modulo-7 counter.
- Consumes a sampled count stream, predicts the next value (wrap 6 -> 0) and locks onto a correct sequence.
- Flags and counts sequence errors and out-of-range values; marks wrap events.
- Sits downstream of any mod-N count source as a link and sequence-integrity monitor.

Parameters:
- MOD, 7, modulus of the checked sequence (legal values 0..MOD-1); 2 <= MOD <= 2**WIDTH.
- WIDTH, 3, width of the count sample.
- LOCK_CNT, 3, consecutive in-sequence samples required to assert locked; >= 2.
- UNLOCK_ERR, 2, consecutive mismatches while locked that force loss of lock; >= 1.
- ERRCNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- valid  input  1  count_in is sampled this cycle when high.
- count_in  input  WIDTH  count value from the source.
- clr_err  input  1  synchronous clear of err_count.
- locked  output  1  high while in LOCKED state.
- err_pulse  output  1  one-cycle flag for a detected error.
- wrap_pulse  output  1  one-cycle flag for a correct MOD-1 -> 0 boundary while locked.
- err_count  output  ERRCNT_W  saturating error total.
- expected  output  WIDTH  value predicted for the next valid sample.

Behaviour:
- All outputs registered. Reset (reset=0, async) forces state SEARCH, internal run counters to 0, and locked, err_pulse, wrap_pulse, err_count and expected to 0. Reset mid-operation takes effect immediately, without waiting for clk.
- Update rule: updates occur only on clk edges with valid=1. With valid=0, state, expected and counters hold, and both pulses are 0.
- Latency: response to a sample appears on the clock edge that samples it, so it is visible the following cycle.
- next(x) = 0 if x == MOD-1, else x+1.
- Out-of-range sample (count_in >= MOD), any state: err_pulse=1, err_count increments, state goes to SEARCH, runs clear, expected=0.
- SEARCH, in-range sample: expected=next(count_in), good_run=1, go to VERIFY. No error is counted.
- VERIFY, sample == expected: good_run increments and expected advances. When good_run reaches LOCK_CNT, go to LOCKED and locked=1.
- VERIFY, in-range mismatch: reseed (expected=next(count_in), good_run=1) and stay in VERIFY. No error is counted.
- LOCKED, match: miss_run=0 and expected advances. wrap_pulse=1 if the sample == MOD-1.
- LOCKED, mismatch: err_pulse=1, err_count increments, miss_run increments, and expected advances from the old expected (flywheel), not from the sample.
- Loss of lock: when miss_run reaches UNLOCK_ERR, go to SEARCH, locked=0, expected=0.
- err_count saturates at 2**ERRCNT_W-1 and never wraps.
- clr_err: the clear applies first, then any same-cycle increment, so clr_err plus an error gives err_count=1.
- MOD == 2**WIDTH: the out-of-range check is vacuous, and wrap arithmetic must still return 0 after MOD-1.

Test Plan:
- Reset check: assert reset=0 mid-stream, then release -> locked=0, err_count=0, expected=0, both pulses 0. No clk edge is needed for them to clear.
- Lock-in and wrap: feed valid samples 0,1,2 -> locked=1 after the sample 2 edge. Continue 3,4,5,6,0 -> wrap_pulse=1 for exactly one cycle after the sample 6 edge, and expected=1 after the final edge.
- Single glitch while locked: from lock, feed 3,4,2,6 -> err_pulse once (on the 2), err_count=1, locked stays 1, and 6 matches through the flywheel.
- Loss of lock: from lock with expected=5, feed 1,1 -> err_count increments by 2, locked=0 after the second, expected=0.
- Out of range and valid gating: in SEARCH, feed 7 -> err_pulse=1, err_count=1, state stays SEARCH. Idle with valid=0 for 5 cycles -> no output changes.
- Saturation and clear: force 260 errors -> err_count=255. Then apply clr_err together with an out-of-range sample -> err_count=1. Then clr_err alone -> err_count=0.

Source files
------------

// File: rtl/mod7_sequence_checker.sv
// mod7_sequence_checker
// Receive-side integrity monitor for a modulo-MOD count stream. It predicts
// the next count, locks onto a run of correct samples, and then flags and
// counts mismatches and out-of-range values. While locked it keeps
// predicting from its own expectation (flywheel), so an isolated glitch
// does not knock the prediction off the true sequence. Enough consecutive
// misses drop the lock and restart the search.
module mod7_sequence_checker #(
  parameter int MOD        = 7,
  parameter int WIDTH      = 3,
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_ERR = 2,
  parameter int ERRCNT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid,
  input  logic [WIDTH-1:0]    count_in,
  input  logic                clr_err,
  output logic                locked,
  output logic                err_pulse,
  output logic                wrap_pulse,
  output logic [ERRCNT_W-1:0] err_count,
  output logic [WIDTH-1:0]    expected
);

  // Run counters only need to reach their thresholds.
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_ERR + 1);

  localparam logic [WIDTH-1:0]    LAST_VAL      = WIDTH'(MOD - 1);
  localparam logic [GOOD_W-1:0]   LOCK_TARGET   = GOOD_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0]   UNLOCK_TARGET = MISS_W'(UNLOCK_ERR);
  localparam logic [ERRCNT_W-1:0] ERR_MAX       = '1;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Successor in the modulo sequence. Comparing against LAST_VAL rather
  // than relying on natural overflow keeps a partial-range modulus correct,
  // and when the modulus fills the width the explicit compare still wraps to 0.
  function automatic logic [WIDTH-1:0] mod_next(input logic [WIDTH-1:0] x);
    if (x == LAST_VAL) begin
      return '0;
    end else begin
      return x + WIDTH'(1);
    end
  endfunction

  // Registered state
  state_t              state_q, state_d;
  logic [GOOD_W-1:0]   good_run_q, good_run_d;
  logic [MISS_W-1:0]   miss_run_q, miss_run_d;
  logic [WIDTH-1:0]    expected_q, expected_d;
  logic                locked_q, locked_d;
  logic                err_pulse_q, err_pulse_d;
  logic                wrap_pulse_q, wrap_pulse_d;
  logic [ERRCNT_W-1:0] err_count_q, err_count_d;

  // Combinational helpers
  logic                in_range;
  logic                sample_match;
  logic                err_event;
  logic [GOOD_W-1:0]   good_inc;
  logic [MISS_W-1:0]   miss_inc;
  logic [ERRCNT_W-1:0] err_base;

  // When the modulus fills the whole sample width every code is legal, so
  // the range check collapses to a constant instead of a vacuous compare.
  generate
    if (MOD >= (2 ** WIDTH)) begin : g_full_range
      assign in_range = 1'b1;
    end else begin : g_part_range
      assign in_range = (count_in <= LAST_VAL);
    end
  endgenerate

  assign sample_match = (count_in == expected_q);
  assign good_inc     = good_run_q + GOOD_W'(1);
  assign miss_inc     = miss_run_q + MISS_W'(1);

  // Sequence tracking: decide next state, prediction and pulses per sample.
  always_comb begin
    state_d      = state_q;
    good_run_d   = good_run_q;
    miss_run_d   = miss_run_q;
    expected_d   = expected_q;
    locked_d     = locked_q;
    wrap_pulse_d = 1'b0;
    err_event    = 1'b0;

    if (valid) begin
      if (!in_range) begin
        // Illegal code: always an error, and the stream can no longer be
        // trusted, so restart the search from scratch.
        err_event  = 1'b1;
        state_d    = ST_SEARCH;
        good_run_d = '0;
        miss_run_d = '0;
        expected_d = '0;
        locked_d   = 1'b0;
      end else begin
        case (state_q)
          ST_SEARCH: begin
            // First legal sample seeds the prediction.
            expected_d = mod_next(count_in);
            good_run_d = GOOD_W'(1);
            miss_run_d = '0;
            state_d    = ST_VERIFY;
          end

          ST_VERIFY: begin
            if (sample_match) begin
              expected_d = mod_next(expected_q);
              good_run_d = good_inc;
              if (good_inc == LOCK_TARGET) begin
                state_d    = ST_LOCKED;
                locked_d   = 1'b1;
                miss_run_d = '0;
              end
            end else begin
              // Not locked yet, so a mismatch is just a new candidate start.
              expected_d = mod_next(count_in);
              good_run_d = GOOD_W'(1);
            end
          end

          ST_LOCKED: begin
            // Flywheel: prediction advances from its own value either way.
            expected_d = mod_next(expected_q);
            if (sample_match) begin
              miss_run_d   = '0;
              wrap_pulse_d = (count_in == LAST_VAL);
            end else begin
              err_event = 1'b1;
              if (miss_inc == UNLOCK_TARGET) begin
                state_d    = ST_SEARCH;
                locked_d   = 1'b0;
                expected_d = '0;
                good_run_d = '0;
                miss_run_d = '0;
              end else begin
                miss_run_d = miss_inc;
              end
            end
          end

          default: begin
            // Unused encoding: recover into a clean search.
            state_d    = ST_SEARCH;
            good_run_d = '0;
            miss_run_d = '0;
            expected_d = '0;
            locked_d   = 1'b0;
          end
        endcase
      end
    end

    err_pulse_d = err_event;
  end

  // Error total: clear first, then a same-cycle error counts on top,
  // saturating at all-ones.
  always_comb begin
    err_base    = clr_err ? '0 : err_count_q;
    err_count_d = err_base;
    if (err_event && (err_base != ERR_MAX)) begin
      err_count_d = err_base + ERRCNT_W'(1);
    end
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_SEARCH;
      good_run_q   <= '0;
      miss_run_q   <= '0;
      expected_q   <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      good_run_q   <= good_run_d;
      miss_run_q   <= miss_run_d;
      expected_q   <= expected_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      wrap_pulse_q <= wrap_pulse_d;
      err_count_q  <= err_count_d;
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign wrap_pulse = wrap_pulse_q;
  assign err_count  = err_count_q;
  assign expected   = expected_q;

endmodule

// File: tb/tb_mod7_sequence_checker.sv
// Bench for mod7_sequence_checker: directed vector table, hand-written
// corner sequences (saturation, clear priority, async reset) and a random
// phase checked against a behavioural model of the sequence rules.
module tb_mod7_sequence_checker;

  localparam int MOD        = 7;
  localparam int WIDTH      = 3;
  localparam int LOCK_CNT   = 3;
  localparam int UNLOCK_ERR = 2;
  localparam int ERRCNT_W   = 8;
  localparam int ERR_SAT    = (1 << ERRCNT_W) - 1;

  logic                clk;
  logic                reset;
  logic                valid;
  logic [WIDTH-1:0]    count_in;
  logic                clr_err;
  logic                locked;
  logic                err_pulse;
  logic                wrap_pulse;
  logic [ERRCNT_W-1:0] err_count;
  logic [WIDTH-1:0]    expected;

  int n_checks = 0;
  int n_fail   = 0;

  mod7_sequence_checker #(
    .MOD(MOD), .WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT),
    .UNLOCK_ERR(UNLOCK_ERR), .ERRCNT_W(ERRCNT_W)
  ) dut (
    .clk(clk), .reset(reset), .valid(valid), .count_in(count_in),
    .clr_err(clr_err), .locked(locked), .err_pulse(err_pulse),
    .wrap_pulse(wrap_pulse), .err_count(err_count), .expected(expected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [2:0] cin;
    logic       clr;
    logic       locked;
    logic       errp;
    logic       wrap;
    int         ecnt;
    int         exp_val;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic v, input int c, input logic clr,
                              input logic lk, input logic ep, input logic wp,
                              input int ec, input int ex);
    vec_t r;
    r.valid = v; r.cin = c[2:0]; r.clr = clr;
    r.locked = lk; r.errp = ep; r.wrap = wp; r.ecnt = ec; r.exp_val = ex;
    vecs.push_back(r);
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_all(input string tag, input int lk, input int ep,
                           input int wp, input int ec, input int ex);
    check({tag, " locked"},     int'(locked),     lk);
    check({tag, " err_pulse"},  int'(err_pulse),  ep);
    check({tag, " wrap_pulse"}, int'(wrap_pulse), wp);
    check({tag, " err_count"},  int'(err_count),  ec);
    check({tag, " expected"},   int'(expected),   ex);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there.
  task automatic drive(input logic v, input int c, input logic clr);
    valid    = v;
    count_in = c[WIDTH-1:0];
    clr_err  = clr;
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: "run" counts consecutive consistent samples
  // while hunting (0 means nothing seen yet), "lk" is the lock flag.
  int m_lk, m_run, m_miss, m_pred, m_cnt, m_errp, m_wrap;

  task automatic model_reset();
    m_lk = 0; m_run = 0; m_miss = 0; m_pred = 0; m_cnt = 0;
    m_errp = 0; m_wrap = 0;
  endtask

  task automatic model_step(input int v, input int c, input int clr);
    int err;
    err = 0;
    m_wrap = 0;
    if (v != 0) begin
      if (c >= MOD) begin
        err = 1; m_lk = 0; m_run = 0; m_miss = 0; m_pred = 0;
      end else if (m_lk == 0) begin
        if (m_run > 0 && c == m_pred) m_run = m_run + 1;
        else m_run = 1;
        m_pred = (c + 1) % MOD;
        if (m_run >= LOCK_CNT) begin
          m_lk = 1; m_miss = 0;
        end
      end else begin
        if (c == m_pred) begin
          m_miss = 0;
          m_wrap = (c == MOD - 1) ? 1 : 0;
        end else begin
          err = 1;
          m_miss = m_miss + 1;
        end
        m_pred = (m_pred + 1) % MOD;
        if (m_miss >= UNLOCK_ERR) begin
          m_lk = 0; m_run = 0; m_miss = 0; m_pred = 0;
        end
      end
    end
    if (clr != 0) m_cnt = 0;
    if (err != 0 && m_cnt < ERR_SAT) m_cnt = m_cnt + 1;
    m_errp = err;
  endtask

  initial begin
    valid = 1'b0; count_in = '0; clr_err = 1'b0; reset = 1'b0;

    // Directed table: valid, count_in, clr | locked, err_p, wrap, err_cnt, expected
    add(1, 0, 0,  0, 0, 0, 0, 1);
    add(1, 1, 0,  0, 0, 0, 0, 2);
    add(1, 2, 0,  1, 0, 0, 0, 3);
    add(1, 3, 0,  1, 0, 0, 0, 4);
    add(1, 4, 0,  1, 0, 0, 0, 5);
    add(1, 5, 0,  1, 0, 0, 0, 6);
    add(1, 6, 0,  1, 0, 1, 0, 0);
    add(1, 0, 0,  1, 0, 0, 0, 1);
    add(1, 1, 0,  1, 0, 0, 0, 2);
    add(1, 2, 0,  1, 0, 0, 0, 3);
    add(1, 3, 0,  1, 0, 0, 0, 4);   // glitch sequence 3,4,2,6
    add(1, 4, 0,  1, 0, 0, 0, 5);
    add(1, 2, 0,  1, 1, 0, 1, 6);
    add(1, 6, 0,  1, 0, 1, 1, 0);
    add(1, 0, 0,  1, 0, 0, 1, 1);
    add(1, 1, 0,  1, 0, 0, 1, 2);
    add(1, 2, 0,  1, 0, 0, 1, 3);
    add(1, 3, 0,  1, 0, 0, 1, 4);
    add(1, 4, 0,  1, 0, 0, 1, 5);
    add(1, 1, 0,  1, 1, 0, 2, 6);   // loss of lock: 1,1 with expected 5
    add(1, 1, 0,  0, 1, 0, 3, 0);
    add(1, 7, 0,  0, 1, 0, 4, 0);   // out of range in SEARCH
    add(0, 3, 0,  0, 0, 0, 4, 0);   // idle, valid gating
    add(0, 0, 0,  0, 0, 0, 4, 0);
    add(0, 6, 0,  0, 0, 0, 4, 0);
    add(0, 7, 0,  0, 0, 0, 4, 0);
    add(0, 1, 0,  0, 0, 0, 4, 0);
    add(1, 4, 0,  0, 0, 0, 4, 5);   // VERIFY reseed without error
    add(1, 2, 0,  0, 0, 0, 4, 3);
    add(1, 3, 0,  0, 0, 0, 4, 4);
    add(1, 4, 0,  1, 0, 0, 4, 5);
    add(0, 5, 0,  1, 0, 0, 4, 5);
    add(1, 5, 1,  1, 0, 0, 0, 6);   // clr_err alone while matching

    // Reset state before any clock edge has been seen
    #2;
    check_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].valid, int'(vecs[i].cin), vecs[i].clr);
      $display("vec %0d: valid=%0d in=%0d clr=%0d -> locked=%0d err=%0d wrap=%0d cnt=%0d exp=%0d",
               i, vecs[i].valid, vecs[i].cin, vecs[i].clr, locked, err_pulse,
               wrap_pulse, err_count, expected);
      check_all($sformatf("vec%0d", i), int'(vecs[i].locked), int'(vecs[i].errp),
                int'(vecs[i].wrap), vecs[i].ecnt, vecs[i].exp_val);
    end

    // Saturation: 260 out-of-range samples on top of the cleared count
    for (int i = 0; i < 260; i++) drive(1, 7, 0);
    $display("saturate: err_count=%0d", err_count);
    check("saturate err_count", int'(err_count), ERR_SAT);
    check("saturate locked", int'(locked), 0);
    drive(1, 7, 1);
    $display("clr+error: err_count=%0d", err_count);
    check("clr+error err_count", int'(err_count), 1);
    drive(0, 0, 1);
    $display("clr alone: err_count=%0d", err_count);
    check("clr alone err_count", int'(err_count), 0);

    // Async reset mid-stream: lock, make an error, then reset off-edge
    drive(1, 0, 0);
    drive(1, 1, 0);
    drive(1, 2, 0);
    drive(1, 5, 0);
    check_all("pre-reset", 1, 1, 0, 1, 4);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    $display("async reset: locked=%0d err=%0d cnt=%0d exp=%0d", locked, err_pulse, err_count, expected);
    check_all("async reset", 0, 0, 0, 0, 0);
    valid = 1'b1; count_in = 3'd3;
    @(posedge clk);
    #1;
    check_all("held reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    valid = 1'b0;
    reset = 1'b1;
    #1;
    check_all("reset release", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    // Random phase against the behavioural model
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int v, c, clr;
      v   = ($urandom_range(0, 99) < 85) ? 1 : 0;
      clr = ($urandom_range(0, 99) < 3) ? 1 : 0;
      if ($urandom_range(0, 99) < 80) c = m_pred;
      else c = $urandom_range(0, 7);
      model_step(v, c, clr);
      drive(v[0], c, clr[0]);
      $display("rand %0d: valid=%0d in=%0d clr=%0d -> locked=%0d err=%0d wrap=%0d cnt=%0d exp=%0d",
               cyc, v, c, clr, locked, err_pulse, wrap_pulse, err_count, expected);
      check($sformatf("rand%0d outputs", cyc),
            int'({locked, err_pulse, wrap_pulse, err_count, expected}),
            (m_lk << 13) | (m_errp << 12) | (m_wrap << 11) | (m_cnt << 3) | m_pred);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
